// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and encodings for the IF/DM memory port arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_e;
  localparam logic [1:0] BHW_BYTE = 2'd0;
  localparam logic [1:0] BHW_HALF = 2'd1;
  localparam logic [1:0] BHW_WORD = 2'd2;
  localparam logic SRC_IF = 1'b0;
  localparam logic SRC_DM = 1'b1;
endpackage

// File: rtl/arb_timeout_ctr.sv
// arb_timeout_ctr: busy-cycle watchdog for one memory access
//  clk, rst   clock and synchronous active-high reset
//  load_i     access granted this cycle; arm for TIMEOUT busy cycles
//  dec_i      access in flight this cycle
//  expire_o   this is the last allowed busy cycle without an ack
module arb_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic dec_i,
  output logic expire_o
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] cnt_q, cnt_d;
  // Loaded with TIMEOUT-1 so that the TIMEOUT-th busy cycle sees zero.
  always_comb cnt_d = load_i ? W'(TIMEOUT - 1) : (dec_i && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign expire_o = dec_i && cnt_q == '0;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and data access
//  Clk/Reset            clock, synchronous active-high reset
//  if_req/if_addr       fetch request -> if_gnt, if_rvalid, if_rdata[31:0]
//  dm_req/we/bhw/addr/wdata  data request -> dm_gnt, dm_rvalid, dm_rdata
//  mem_req/we/bhw/addr/wdata -> memory, mem_rdata/mem_ack <- memory
//  err                  one-cycle pulse when an access times out
//  stall                fetch waiting (if_req & ~if_rvalid)
//  Optional macro ARB_FAIR_EN: bound consecutive DM grants while IF waits.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int TIMEOUT      = 16,
  parameter int MAX_DM_BURST = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [1:0]        dm_bhw,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [1:0]        mem_bhw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              err,
  output logic              stall
);
  state_e state_q, state_d;
  logic if_rvalid_q, dm_rvalid_q, err_q, mem_we_q;
  logic [31:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q, mem_wdata_q;
  logic [1:0] mem_bhw_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic busy, can_grant, if_first, expire, done, abort, fin_if, fin_dm, src;
  assign busy = state_q != IDLE;
  // The completion-pulse cycle is a dead cycle: no grant while rvalid is up.
  assign can_grant = !busy && !if_rvalid_q && !dm_rvalid_q && !Reset;
`ifdef ARB_FAIR_EN
  localparam int BW = $clog2(MAX_DM_BURST + 1);
  logic [BW-1:0] burst_q, burst_d;
  assign if_first = burst_q == BW'(MAX_DM_BURST);
  always_comb burst_d = if_gnt ? '0 : (dm_gnt && if_req) ? burst_q + BW'(1) : burst_q;
  always_ff @(posedge Clk) burst_q <= Reset ? '0 : burst_d;
`else
  assign if_first = 1'b0;
`endif
  assign dm_gnt = can_grant && dm_req && !(if_first && if_req);
  assign if_gnt = can_grant && if_req && (!dm_req || if_first);
  assign src = dm_gnt ? SRC_DM : SRC_IF;
  // An ack in the expiry cycle completes normally.
  assign done = busy && mem_ack;
  assign abort = expire && !mem_ack;
  assign fin_if = state_q == BUSY_IF && (done || abort);
  assign fin_dm = state_q == BUSY_DM && (done || abort);
  arb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk(Clk),
    .rst(Reset),
    .load_i(if_gnt || dm_gnt),
    .dec_i(busy),
    .expire_o(expire)
  );
  always_comb state_d = if_gnt ? BUSY_IF : dm_gnt ? BUSY_DM : (done || abort) ? IDLE : state_q;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      err_q       <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_bhw_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      if_rvalid_q <= fin_if;
      dm_rvalid_q <= fin_dm;
      err_q       <= abort;
      if (fin_if) if_rdata_q <= done ? mem_rdata[31:0] : '0;
      if (fin_dm) dm_rdata_q <= (done && !mem_we_q) ? mem_rdata : '0;
      if (if_gnt || dm_gnt) begin
        mem_we_q    <= src == SRC_DM && dm_we;
        mem_bhw_q   <= src == SRC_DM ? dm_bhw : BHW_WORD;
        mem_addr_q  <= src == SRC_DM ? dm_addr : if_addr & ~ADDR_W'(3);
        mem_wdata_q <= src == SRC_DM ? dm_wdata : '0;
      end
    end
  end
  assign mem_req   = busy;
  assign mem_we    = mem_we_q;
  assign mem_bhw   = mem_bhw_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rvalid = dm_rvalid_q;
  assign dm_rdata  = dm_rdata_q;
  assign err       = err_q;
  assign stall     = if_req && !if_rvalid_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks against a transaction-level model
module tb_mem_port_arbiter;
  localparam int TIMEOUT = 16;
  localparam int MAXB = 4;
  logic Clk = 1'b0, Reset = 1'b1;
  logic if_req = 0, dm_req = 0, dm_we = 0, mem_ack = 0;
  logic [63:0] if_addr = 0, dm_addr = 0, dm_wdata = 0, mem_rdata = 0;
  logic [1:0] dm_bhw = 0;
  logic if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_req, mem_we, err, stall;
  logic [31:0] if_rdata;
  logic [63:0] dm_rdata, mem_addr, mem_wdata;
  logic [1:0] mem_bhw;
  int checks = 0, failures = 0;
  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(TIMEOUT), .MAX_DM_BURST(MAXB)) dut (
    .Clk(Clk), .Reset(Reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_bhw(dm_bhw), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_bhw(mem_bhw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err), .stall(stall)
  );
  always #5 Clk = ~Clk;
  // Model: the access in flight (0 none, 1 IF, 2 DM), how many busy cycles it has used,
  // what was latched at grant, and the completion pulse visible this cycle.
  int m_busy = 0, m_len = 0, m_burst = 0;
  logic m_we = 0, m_ifv = 0, m_dmv = 0, m_err = 0;
  logic [1:0] m_bhw = 0;
  logic [63:0] m_addr = 0, m_wdata = 0, m_dmd = 0;
  logic [31:0] m_ifd = 0;
  int gq[$];
  function automatic int exp_gnt();
    bit fair;
    fair = 0;
`ifdef ARB_FAIR_EN
    fair = m_burst >= MAXB;
`endif
    if (Reset || m_busy != 0 || m_ifv || m_dmv) return 0;
    if (dm_req && !(fair && if_req)) return 2;
    if (if_req) return 1;
    return 0;
  endfunction
  task automatic model_edge();
    int g;
    bit ok;
    g = exp_gnt();
    if (Reset) begin
      m_busy = 0; m_len = 0; m_burst = 0; m_we = 0; m_bhw = 0; m_addr = 0; m_wdata = 0;
      m_ifv = 0; m_dmv = 0; m_err = 0; m_ifd = 0; m_dmd = 0;
      return;
    end
    m_ifv = 0; m_dmv = 0; m_err = 0;
    if (m_busy != 0) begin
      if (mem_ack || m_len == TIMEOUT) begin
        ok = mem_ack;
        if (m_busy == 1) begin m_ifv = 1; m_ifd = ok ? mem_rdata[31:0] : 32'h0; end
        else begin m_dmv = 1; m_dmd = (ok && !m_we) ? mem_rdata : 64'h0; end
        m_err = !ok;
        m_busy = 0;
      end else m_len++;
    end
    if (g != 0) begin
      gq.push_back(g);
      m_busy = g; m_len = 1;
      m_we = g == 2 && dm_we;
      m_bhw = g == 2 ? dm_bhw : 2'd2;
      m_addr = g == 2 ? dm_addr : {if_addr[63:2], 2'b00};
      m_wdata = g == 2 ? dm_wdata : 64'h0;
      if (g == 1) m_burst = 0;
      else if (if_req) m_burst++;
    end
  endtask
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", n, a, e, $time);
    end
  endtask
  task automatic tick();
    @(posedge Clk);
    #1;
    model_edge();
  endtask
  task automatic check();
    int g;
    #1;
    g = exp_gnt();
    chk("if_gnt", if_gnt, g == 1);
    chk("dm_gnt", dm_gnt, g == 2);
    chk("mem_req", mem_req, m_busy != 0);
    chk("mem_we", mem_we, m_we);
    chk("mem_bhw", mem_bhw, m_bhw);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("if_rvalid", if_rvalid, m_ifv);
    chk("dm_rvalid", dm_rvalid, m_dmv);
    chk("err", err, m_err);
    chk("stall", stall, if_req && !m_ifv);
    if (m_ifv) chk("if_rdata", if_rdata, m_ifd);
    if (m_dmv) chk("dm_rdata", dm_rdata, m_dmd);
  endtask
  initial begin
    int ack_mode;
    tick(); tick();
    check();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_rvalid", {if_rvalid, dm_rvalid, err}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    tick(); Reset = 0; check();
    // fetch only
    tick(); if_req = 1; if_addr = 64'h8; check();
    chk("t1_gnt", if_gnt, 1);
    tick(); mem_ack = 1; mem_rdata = 64'h1122334455667788; check();
    chk("t1_mem_req", mem_req, 1);
    chk("t1_mem_addr", mem_addr, 64'h8);
    tick(); mem_ack = 0; if_req = 0; check();
    chk("t1_rvalid", if_rvalid, 1);
    chk("t1_rdata", if_rdata, 64'h55667788);
    // simultaneous requests, DM wins
    tick(); if_req = 1; if_addr = 64'h104; dm_req = 1; dm_we = 0; dm_bhw = 2; dm_addr = 64'h10; check();
    chk("t2_dm_first", {dm_gnt, if_gnt}, 2'b10);
    chk("t2_stall0", stall, 1);
    tick(); mem_ack = 1; check();
    tick(); mem_ack = 0; dm_req = 0; check();
    chk("t2_dm_rvalid", dm_rvalid, 1);
    chk("t2_no_gnt", if_gnt, 0);
    chk("t2_stall2", stall, 1);
    tick(); check();
    chk("t2_if_gnt_t3", if_gnt, 1);
    tick(); mem_ack = 1; check();
    tick(); mem_ack = 0; if_req = 0; check();
    chk("t2_if_rvalid", if_rvalid, 1);
    // store
    tick(); dm_req = 1; dm_we = 1; dm_bhw = 0; dm_addr = 64'h13; dm_wdata = 64'hAB; check();
    tick(); mem_ack = 1; mem_rdata = '1; check();
    chk("t3_mem_we", mem_we, 1);
    chk("t3_mem_bhw", mem_bhw, 0);
    chk("t3_mem_addr", mem_addr, 64'h13);
    chk("t3_mem_wdata", mem_wdata, 64'hAB);
    tick(); mem_ack = 0; dm_req = 0; check();
    chk("t3_rvalid", dm_rvalid, 1);
    chk("t3_rdata0", dm_rdata, 0);
    // timeout with no ack
    tick(); dm_req = 1; dm_we = 0; dm_bhw = 2; dm_addr = 64'h20; check();
    for (int k = 1; k <= TIMEOUT; k++) begin tick(); mem_ack = 0; check(); end
    tick(); dm_req = 0; check();
    chk("t4_err", err, 1);
    chk("t4_rvalid", dm_rvalid, 1);
    chk("t4_rdata0", dm_rdata, 0);
    // ack on the last allowed busy cycle
    tick(); dm_req = 1; dm_addr = 64'h28; check();
    for (int k = 1; k <= TIMEOUT; k++) begin
      tick(); mem_ack = k == TIMEOUT; mem_rdata = 64'h0123456789ABCDEF; check();
    end
    tick(); mem_ack = 0; dm_req = 0; check();
    chk("t4b_no_err", err, 0);
    chk("t4b_rvalid", dm_rvalid, 1);
    chk("t4b_rdata", dm_rdata, 64'h0123456789ABCDEF);
    // reset two cycles into a store
    tick(); dm_req = 1; dm_we = 1; dm_bhw = 2; dm_addr = 64'h40; dm_wdata = 64'h55; check();
    tick(); check();
    tick(); Reset = 1; dm_req = 0; check();
    tick(); Reset = 0; mem_ack = 1; check();
    chk("t5_mem_req", mem_req, 0);
    chk("t5_mem_fields", {mem_we, mem_bhw, mem_addr, mem_wdata}, 0);
    chk("t5_pulses", {if_rvalid, dm_rvalid, err, if_gnt, dm_gnt}, 0);
    tick(); mem_ack = 0; check();
    chk("t5_late_ack", {dm_rvalid, err}, 0);
    // both requesters held high
    gq.delete();
    for (int k = 0; k < 30; k++) begin
      tick(); if_req = 1; if_addr = 64'h200; dm_req = 1; dm_we = 0; dm_addr = 64'h300; mem_ack = 1; check();
    end
    chk("t6_ngrants", gq.size() >= 10, 1);
    for (int i = 0; i < 10 && i < gq.size(); i++) begin
`ifdef ARB_FAIR_EN
      chk($sformatf("t6_order%0d", i), gq[i], (i % 5 == 4) ? 1 : 2);
`else
      chk($sformatf("t6_order%0d", i), gq[i], 2);
`endif
    end
    tick(); if_req = 0; dm_req = 0; mem_ack = 0; check();
    // randomized traffic, acks, withheld-ack windows and resets
    ack_mode = 1;
    for (int n = 0; n < 4000; n++) begin
      tick();
      if (n % 250 == 0) ack_mode = $urandom_range(0, 3);
      Reset = $urandom_range(0, 199) == 0;
      if (Reset || m_ifv) if_req = 0;
      else if (!if_req && $urandom_range(0, 3) == 0) begin
        if_req = 1; if_addr = {$urandom, $urandom};
      end
      if (Reset || m_dmv) dm_req = 0;
      else if (!dm_req && $urandom_range(0, 3) == 0) begin
        dm_req = 1; dm_we = 1'($urandom_range(0, 1)); dm_bhw = 2'($urandom_range(0, 2));
        dm_addr = {$urandom, $urandom}; dm_wdata = {$urandom, $urandom};
      end
      mem_ack = ack_mode != 0 && $urandom_range(0, ack_mode) == 0;
      mem_rdata = {$urandom, $urandom};
      check();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
